// File: rtl/seq_det_pkg.sv
// Shared types and constants for the seq_detect_param serial pattern detector.
// Optional counter is controlled by the SEQ_DET_CNT_EN macro (see seq_detect_param.sv).
package seq_det_pkg;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_e;

  localparam int          DEF_PAT_W   = 8;
  localparam int          DEF_CNT_W   = 16;
  localparam logic [7:0]  DEF_RST_PAT = 8'h0B;
  localparam int          DEF_RST_LEN = 4;
  localparam logic        DEF_RST_OVL = 1'b1;

  // Width of a field that can hold any length 0..pat_w inclusive.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Stream, configuration and result signals of seq_detect_param.
// The detector takes the slave view; a driver/bench takes the master view.
interface seq_detect_param_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int LEN_W = len_w(PAT_W);

  logic             data;
  logic             data_vld;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_ovl;
  logic             flag;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output data, data_vld, cfg_load, cfg_pat, cfg_len, cfg_ovl,
    input  flag, match_cnt
  );

  modport slave (
    input  data, data_vld, cfg_load, cfg_pat, cfg_len, cfg_ovl,
    output flag, match_cnt
  );
endinterface

// File: rtl/seq_det_cmp.sv
// Combinational match check: compares the low `len` bits of the next history
// against the pattern, gated by enough history and a non-zero length.
module seq_det_cmp
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic [PAT_W-1:0] hist_next,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic [LEN_W-1:0] fill_next,
  output logic             hit
);

  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] diff;

  for (genvar i = 0; i < PAT_W; i++) begin : g_mask
    assign mask[i] = (LEN_W'(i) < len);
  end

  assign diff = (hist_next ^ pat) & mask;
  assign hit  = (len != '0) && (fill_next >= len) && (diff == '0);

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with overlap select.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
  parameter int               RST_LEN = DEF_RST_LEN,
  parameter logic             RST_OVL = DEF_RST_OVL
) (
  input  logic                clk,
  input  logic                rst,
  seq_detect_param_if.slave   bus
);

  localparam int LEN_W = len_w(PAT_W);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  ovl_e             ovl;
  logic             flag;

  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill_next;
  logic [LEN_W-1:0] len_clamped;
  logic             hit;
  logic             take_bit;

  // A bit arriving with cfg_load is dropped so the new config starts clean.
  assign take_bit    = bus.data_vld && !bus.cfg_load;
  assign hist_next   = {hist[PAT_W-2:0], bus.data};
  assign fill_next   = (fill == LEN_MAX) ? fill : fill + 1'b1;
  assign len_clamped = (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;

  seq_det_cmp #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_cmp (
    .hist_next (hist_next),
    .pat       (pat),
    .len       (len),
    .fill_next (fill_next),
    .hit       (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
      pat  <= RST_PAT;
      len  <= LEN_W'(RST_LEN);
      ovl  <= ovl_e'(RST_OVL);
      flag <= 1'b0;
    end else if (bus.cfg_load) begin
      hist <= '0;
      fill <= '0;
      pat  <= bus.cfg_pat;
      len  <= len_clamped;
      ovl  <= ovl_e'(bus.cfg_ovl);
      flag <= 1'b0;
    end else if (bus.data_vld) begin
      hist <= hist_next;
      // Non-overlap mode forgets the matched bits by emptying the history count.
      fill <= (hit && ovl == OVL_OFF) ? '0 : fill_next;
      flag <= hit;
    end else begin
      flag <= 1'b0;
    end
  end

  assign bus.flag = flag;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (take_bit && hit && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.match_cnt = cnt;
`else
  logic unused_take_bit;
  assign unused_take_bit = take_bit;
  assign bus.match_cnt   = '0;
`endif

endmodule
